// File: rtl/decodificador_comp2_serial_pkg.sv
// Shared definitions for the serial two's-complement decoder.
//   N_DEFAULT : default word width
//   state_t   : FSM state encodings (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2),
//               kept stable so other benches of the negator can reuse them.
package decodificador_comp2_serial_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/decodificador_comp2_serial_celda.sv
// One bit-slice of the serial two's-complement-to-magnitude conversion.
// Negative words are converted by copying bits up to and including the
// first 1 (from the LSB), then inverting all following bits (== ~X+1).
// Ports:
//   x_i          : current input bit (LSB first)
//   signo        : 1 when the word being decoded is negative
//   seen_one     : a 1 has already been seen in a lower bit
//   out_bit      : magnitude bit for this position
//   seen_one_nxt : updated seen_one flag for the next bit
module celda_comp2_serial (
  input  logic x_i,
  input  logic signo,
  input  logic seen_one,
  output logic out_bit,
  output logic seen_one_nxt
);

  assign out_bit      = x_i ^ (signo & seen_one);
  assign seen_one_nxt = seen_one | x_i;

endmodule

// File: rtl/decodificador_comp2_serial.sv
// Bit-serial decoder: N-bit two's-complement word -> sign + unsigned magnitude.
// One bit per clock, LSB first; one word in flight at a time.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  : input handshake (in_ready high only in IDLE)
//   X                   : two's-complement word, sampled on acceptance only
//   out_valid, out_ready: output handshake (results held while stalled)
//   signo               : 1 = negative input
//   magnitud            : |X|, N bits so that -2^(N-1) fits
//   es_minimo           : input was the most negative value -2^(N-1)
module decodificador_comp2_serial
  import decodificador_comp2_serial_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         signo,
  output logic [N-1:0] magnitud,
  output logic         es_minimo
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          seen_one;
  logic          out_bit;
  logic          seen_one_nxt;

  celda_comp2_serial u_celda (
    .x_i          (shreg[0]),
    .signo        (signo),
    .seen_one     (seen_one),
    .out_bit      (out_bit),
    .seen_one_nxt (seen_one_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch on acceptance, then one serial bit per SHIFT cycle.
  // Magnitude fills from the MSB side so after N shifts bit 0 sits at LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      seen_one  <= 1'b0;
      signo     <= 1'b0;
      magnitud  <= '0;
      es_minimo <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg     <= X;
            signo     <= X[N-1];
            es_minimo <= X[N-1] & ~(|X[N-2:0]);
            cnt       <= '0;
            seen_one  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          shreg    <= shreg >> 1;
          magnitud <= {out_bit, magnitud[N-1:1]};
          seen_one <= seen_one_nxt;
          cnt      <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decodificador_comp2_serial.sv
module tb_decodificador_comp2_serial;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic         out_valid;
  logic         out_ready;
  logic         signo;
  logic [N-1:0] magnitud;
  logic         es_minimo;

  int checks = 0;
  int errors = 0;

  decodificador_comp2_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .signo     (signo),
    .magnitud  (magnitud),
    .es_minimo (es_minimo)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the integer value of the word.
  function automatic int ref_value(input logic [N-1:0] x);
    return x[N-1] ? int'(x) - (1 << N) : int'(x);
  endfunction
  function automatic logic [N-1:0] ref_mag(input logic [N-1:0] x);
    int v;
    v = ref_value(x);
    if (v < 0) v = -v;
    return v[N-1:0];
  endfunction
  function automatic logic ref_sign(input logic [N-1:0] x);
    return ref_value(x) < 0;
  endfunction
  function automatic logic ref_min(input logic [N-1:0] x);
    return ref_value(x) == -(1 << (N - 1));
  endfunction

  // Present a word and return once it has been accepted (time = edge + 1).
  task automatic send_word(input logic [N-1:0] x, output logic timeout);
    int k;
    timeout = 1'b0;
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    if (in_ready !== 1'b1) timeout = 1'b1;
    in_valid = 1'b1;
    X        = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    X        = N'($urandom);
  endtask

  // Wait (bounded) for out_valid, sampled 1 unit after each edge.
  task automatic wait_valid(output logic timeout);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    timeout = (out_valid !== 1'b1);
  endtask

  // Full transaction with out_ready held high; returns captured result.
  task automatic run_word(input logic [N-1:0] x, output logic s,
                          output logic [N-1:0] m, output logic e,
                          output logic timeout);
    logic to1, to2;
    out_ready = 1'b1;
    send_word(x, to1);
    wait_valid(to2);
    s = signo; m = magnitud; e = es_minimo;
    timeout = to1 | to2;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, signo, magnitud, es_minimo} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b signo=%b mag=%h min=%b, want all 0",
               out_valid, signo, magnitud, es_minimo);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    logic to;
    int   first;
    out_ready = 1'b1;
    send_word(8'h05, to);
    first = -1;
    for (int k = 1; k <= N + 2; k++) begin
      if (out_valid === 1'b1 && first < 0) first = k - 1;
      if (first < 0) begin @(posedge clk); #1; end
    end
    checks++;
    if (to || first != N) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges (timeout=%b), want %0d", first, to, N);
    end
    checks++;
    if (signo !== 1'b0 || magnitud !== 8'h05 || es_minimo !== 1'b0) begin
      errors++;
      $display("FAIL pos_05: got signo=%b mag=%h min=%b, want 0 05 0", signo, magnitud, es_minimo);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL consume_05: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_values();
    logic [N-1:0] vec [6] = '{8'hFB, 8'hFF, 8'h00, 8'h80, 8'h81, 8'h7F};
    logic s, e, to;
    logic [N-1:0] m;
    for (int i = 0; i < 6; i++) begin
      run_word(vec[i], s, m, e, to);
      checks++;
      if (to || s !== ref_sign(vec[i]) || m !== ref_mag(vec[i]) || e !== ref_min(vec[i])) begin
        errors++;
        $display("FAIL value_%h: got signo=%b mag=%h min=%b to=%b, want %b %h %b",
                 vec[i], s, m, e, to, ref_sign(vec[i]), ref_mag(vec[i]), ref_min(vec[i]));
      end
    end
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] x;
      x = N'($urandom);
      run_word(x, s, m, e, to);
      checks++;
      if (to || s !== ref_sign(x) || m !== ref_mag(x) || e !== ref_min(x)) begin
        errors++;
        $display("FAIL random_%h: got signo=%b mag=%h min=%b, want %b %h %b",
                 x, s, m, e, ref_sign(x), ref_mag(x), ref_min(x));
      end
    end
  endtask

  task automatic test_backpressure();
    logic to;
    logic [N-1:0] x, m0;
    logic s0, e0;
    x = 8'hC8 | N'($urandom_range(0, 7));
    out_ready = 1'b0;
    send_word(x, to);
    // A second word offered during SHIFT must be ignored.
    in_valid = 1'b1; X = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(to);
    s0 = signo; m0 = magnitud; e0 = es_minimo;
    checks++;
    if (to || s0 !== ref_sign(x) || m0 !== ref_mag(x) || e0 !== ref_min(x)) begin
      errors++;
      $display("FAIL bp_value_%h: got signo=%b mag=%h min=%b, want %b %h %b",
               x, s0, m0, e0, ref_sign(x), ref_mag(x), ref_min(x));
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || signo !== s0 ||
          magnitud !== m0 || es_minimo !== e0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b in_ready=%b mag=%h, want 1 0 %h",
                 k, out_valid, in_ready, magnitud, m0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic to, seen, s, e;
    logic [N-1:0] m;
    out_ready = 1'b1;
    send_word(8'h55, to);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, signo, magnitud, es_minimo} !== '0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b signo=%b mag=%h min=%b, want all 0",
               out_valid, signo, magnitud, es_minimo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got out_valid seen=%b, want 0", seen);
    end
    run_word(8'h9C, s, m, e, to);
    checks++;
    if (to || s !== 1'b1 || m !== 8'h64 || e !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_9C: got signo=%b mag=%h min=%b, want 1 64 0", s, m, e);
    end
  endtask

  task automatic test_back_to_back();
    logic s, e, to;
    logic [N-1:0] m, x;
    for (int v = 0; v < (1 << N); v++) begin
      x = N'(v);
      run_word(x, s, m, e, to);
      checks++;
      if (to || s !== ref_sign(x) || m !== ref_mag(x) || e !== ref_min(x)) begin
        errors++;
        $display("FAIL sweep_%h: got signo=%b mag=%h min=%b, want %b %h %b",
                 x, s, m, e, ref_sign(x), ref_mag(x), ref_min(x));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
